hilo_mul_unit: RTL and testbench
================================

Name: hilo_mul_unit

Overview:
- Execute-stage consumer of the 5-bit ALUInstruction bus for the HI/LO instruction group: MULT, MULTU, MADD, MSUB, MTHI, MTLO, MFHI, MFLO.
- Owns the architectural HI and LO registers.
- Runs multiplies on an iterative shift-add engine; asserts Stall so the pipeline holds any HI/LO-group instruction that arrives while a multiply is in flight.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4; N = 32/BITS_PER_CYCLE.
- WIDTH, 32, operand width; fixed at 32, present for package consistency only.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  ALUInstruction/A/B valid this cycle.
- ALUInstruction  input  5  operation code from Control.
- A  input  32  rs operand.
- B  input  32  rt operand.
- Stall  output  1  combinational; high when Start is high, ALUInstruction is in the HI/LO group, and Busy is high.
- Busy  output  1  multiply in flight.
- Done  output  1  one-cycle pulse in the cycle after HI/LO is written by a multiply.
- HiLoOut  output  32  combinational; HI when ALUInstruction=MFHI, LO when MFLO, else 0.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- Reset: HI, LO, Busy and Done are 0. The FSM goes to IDLE and iteration counters clear.
- Reset mid-multiply aborts the operation. Nothing is written except the reset values.
- Codes handled: MULTU 10011, MADD 10100, MSUB 10101, MULT 10110, MFLO 11000, MTHI 11001, MTLO 11010, MFHI 11011.
- Any other code, or Start=0: no state change. Stall=0; HiLoOut follows its own rule.
- Accept: a multiply-class op is accepted at edge E0 when Start=1 and Busy=0.
- FSM IDLE (multiply accepted):
  - Latch |A| and |B| as unsigned 32-bit values; for MULTU, latch A and B raw.
  - Latch result sign = A[31]^B[31] for MULT/MADD/MSUB; 0 for MULTU.
  - Latch op kind, then move to ITER.
- FSM IDLE (MTHI/MTLO): write HI (or LO) = A at E0. Stays IDLE; Busy stays 0.
- FSM ITER:
  - Each edge adds the partial product for BITS_PER_CYCLE multiplier bits into a 64-bit accumulator.
  - After N ITER edges (E1..EN), move to FINISH.
- FSM FINISH, at edge EN+1:
  - P = sign ? -acc : acc, modulo 2^64.
  - MULT/MULTU: {HI,LO}=P.
  - MADD: {HI,LO} = {HI,LO} + P.
  - MSUB: {HI,LO} = {HI,LO} - P.
  - All arithmetic is 64-bit two's complement and wraps silently.
  - Move to IDLE. Done=1 for the cycle following EN+1.
- Busy is high in the cycles between E0 and EN+1. Total latency from accept to HI/LO visible is N+1 edges: 33 with the default.
- Magnitude -(-2^31) = 0x80000000 is handled as unsigned 32-bit; no overflow special case.
- While Busy=1:
  - Start with any HI/LO-group op raises Stall and is ignored; no queue.
  - The issuer must hold the op until Stall drops. Stall is low in the cycle after EN+1, and the op is accepted then.
- HiLoOut is always the registered HI/LO value. There is no bypass of an in-flight result; the stall guarantees MFHI/MFLO never reads stale data.
- Non-HI/LO ops while Busy: Stall=0; the multiply continues undisturbed.
- HI/LO written by FINISH and MTHI/MTLO in the same edge cannot occur, because MT* stalls while Busy.

Decomposition:
- Package mips_alu_pkg holds:
  - the ALUInstruction code constants listed above;
  - a helper function is_hilo_op(code);
  - a helper function is_mult_op(code).
- FSM state encoding (IDLE/ITER/FINISH) is local to the module.
- One sub-module, mul_iter_core: unsigned 32x32 iterative shift-add engine with a load/step interface, a 64-bit accumulator output and a last-step flag, parameterised by BITS_PER_CYCLE.
- Sign handling, accumulate/subtract, HI/LO registers, Stall and Done stay in hilo_mul_unit.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=7, default parameter -> Busy high for 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done pulses once.
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- MTHI A=0, MTLO A=10, then MADD A=4, B=5 -> HI=0, LO=30. Then MSUB A=0x80000000, B=0x80000000 -> {HI,LO} = 30 - 2^62 = HI 0xC0000000, LO 0x0000001E.
- MULT in flight, then MFLO presented with Start -> Stall=1 every cycle until FINISH. MFLO completes the next cycle with HiLoOut = new LO. An ADD presented mid-multiply gives Stall=0.
- Reset asserted at ITER cycle 10 of a MULT -> HI=LO=0, Busy=0 after the edge, no Done pulse. A following MULTU 6×7 gives LO=42, HI=0.
- Repeat the first scenario with BITS_PER_CYCLE=4 -> identical results, Busy for 9 cycles.

Source files
------------

// File: rtl/mips_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_alu_pkg
// Brief   : ALUInstruction codes and decode helpers for the HI/LO group.
// Rev     : 1.0 - initial release
// ============================================================================
package mips_alu_pkg;

    localparam logic [4:0] c_MULTU = 5'b10011;
    localparam logic [4:0] c_MADD  = 5'b10100;
    localparam logic [4:0] c_MSUB  = 5'b10101;
    localparam logic [4:0] c_MULT  = 5'b10110;
    localparam logic [4:0] c_MFLO  = 5'b11000;
    localparam logic [4:0] c_MTHI  = 5'b11001;
    localparam logic [4:0] c_MTLO  = 5'b11010;
    localparam logic [4:0] c_MFHI  = 5'b11011;

    typedef enum logic [1:0] {
        KIND_MUL  = 2'd0,
        KIND_MADD = 2'd1,
        KIND_MSUB = 2'd2
    } op_kind_e;

    function automatic logic is_mult_op(input logic [4:0] code);
        return (code == c_MULTU) || (code == c_MADD) ||
               (code == c_MSUB)  || (code == c_MULT);
    endfunction

    function automatic logic is_hilo_op(input logic [4:0] code);
        return is_mult_op(code) || (code == c_MFLO) || (code == c_MTHI) ||
               (code == c_MTLO) || (code == c_MFHI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter_core.sv
`default_nettype none
// ============================================================================
// Module : mul_iter_core
// Brief  : Unsigned 32x32 iterative shift-add multiplier, BITS_PER_CYCLE/step.
// Rev    : 1.0 - initial release
// ============================================================================
module mul_iter_core #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] mcand_i,
    input  logic [31:0] mplier_i,
    output logic [63:0] acc_o,
    output logic        last_o
);

    localparam int         N      = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] c_LAST = 6'(N - 1);

    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;

    logic [63:0] w_pp [BITS_PER_CYCLE];
    logic [63:0] w_pp_sum;

    // One shifted copy of the multiplicand per multiplier bit retired this step
    generate
        for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_pp
            assign w_pp[k] = mplier_q[k] ? (mcand_q << k) : 64'd0;
        end
    endgenerate

    always_comb begin
        w_pp_sum = 64'd0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_pp_sum = w_pp_sum + w_pp[k];
        end
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = {32'd0, mcand_i};
            mplier_d = mplier_i;
            acc_d    = 64'd0;
            cnt_d    = 6'd0;
        end else if (step_i) begin
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            acc_d    = acc_q + w_pp_sum;
            cnt_d    = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/hilo_mul_unit.sv
`default_nettype none
// ============================================================================
// Module : hilo_mul_unit
// Brief  : HI/LO register owner; MULT/MULTU/MADD/MSUB on an iterative engine.
// Rev    : 1.0 - initial release
// ============================================================================
module hilo_mul_unit
    import mips_alu_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1,
    parameter int WIDTH          = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       ALUInstruction,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiLoOut,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ITER   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        sign_q, sign_d;
    op_kind_e    kind_q, kind_d;
    logic        done_q, done_d;

    logic        w_accept;
    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_core_load;
    logic        w_core_step;
    logic        w_core_last;
    logic [63:0] w_acc;
    logic [63:0] w_prod;
    logic [63:0] w_hilo_new;

    assign w_accept = Start && is_mult_op(ALUInstruction) && (state_q == S_IDLE);
    assign w_signed = (ALUInstruction != c_MULTU);
    // -(-2^31) wraps to 0x80000000, which is the correct unsigned magnitude
    assign w_mag_a  = (w_signed && A[31]) ? (~A + 32'd1) : A;
    assign w_mag_b  = (w_signed && B[31]) ? (~B + 32'd1) : B;

    mul_iter_core #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_core (
        .Clk     (Clk),
        .Reset   (Reset),
        .load_i  (w_core_load),
        .step_i  (w_core_step),
        .mcand_i (w_mag_a),
        .mplier_i(w_mag_b),
        .acc_o   (w_acc),
        .last_o  (w_core_last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (w_accept) state_d = S_ITER;
            S_ITER:   if (w_core_last) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_core_load = w_accept;
        w_core_step = (state_q == S_ITER);
        Busy        = (state_q != S_IDLE);
    end

    assign w_prod = sign_q ? (~w_acc + 64'd1) : w_acc;

    always_comb begin
        w_hilo_new = w_prod;
        case (kind_q)
            KIND_MADD: w_hilo_new = {hi_q, lo_q} + w_prod;
            KIND_MSUB: w_hilo_new = {hi_q, lo_q} - w_prod;
            default:   w_hilo_new = w_prod;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        sign_d = sign_q;
        kind_d = kind_q;
        done_d = (state_q == S_FINISH);
        if (state_q == S_FINISH) begin
            {hi_d, lo_d} = w_hilo_new;
        end else if (state_q == S_IDLE && Start) begin
            if (ALUInstruction == c_MTHI) hi_d = A;
            if (ALUInstruction == c_MTLO) lo_d = A;
        end
        if (w_accept) begin
            sign_d = w_signed && (A[31] ^ B[31]);
            case (ALUInstruction)
                c_MADD:  kind_d = KIND_MADD;
                c_MSUB:  kind_d = KIND_MSUB;
                default: kind_d = KIND_MUL;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            sign_q <= 1'b0;
            kind_q <= KIND_MUL;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            sign_q <= sign_d;
            kind_q <= kind_d;
            done_q <= done_d;
        end
    end

    assign Stall   = Start && is_hilo_op(ALUInstruction) && Busy;
    assign Done    = done_q;
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign HiLoOut = (ALUInstruction == c_MFHI) ? hi_q :
                     (ALUInstruction == c_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mul_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_hilo_mul_unit
// Brief  : Directed self-checking bench for hilo_mul_unit (BPC=1 and BPC=4).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_hilo_mul_unit;

    localparam logic [4:0] MULTU = 5'b10011;
    localparam logic [4:0] MADD  = 5'b10100;
    localparam logic [4:0] MSUB  = 5'b10101;
    localparam logic [4:0] MULT  = 5'b10110;
    localparam logic [4:0] MFLO  = 5'b11000;
    localparam logic [4:0] MTHI  = 5'b11001;
    localparam logic [4:0] MTLO  = 5'b11010;
    localparam logic [4:0] MFHI  = 5'b11011;
    localparam logic [4:0] ADD   = 5'b00010;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [4:0]  Ins;
    logic [31:0] A, B;
    logic        Stall, Busy, Done;
    logic [31:0] HiLoOut, HI, LO;

    logic        Start4;
    logic [4:0]  Ins4;
    logic [31:0] A4, B4;
    logic        Stall4, Busy4, Done4;
    logic [31:0] HiLoOut4, HI4, LO4;

    int checks   = 0;
    int failures = 0;
    int bc, dc, cyc;

    always #5 Clk = ~Clk;

    hilo_mul_unit #(.BITS_PER_CYCLE(1)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ALUInstruction(Ins),
        .A(A), .B(B), .Stall(Stall), .Busy(Busy), .Done(Done),
        .HiLoOut(HiLoOut), .HI(HI), .LO(LO)
    );

    hilo_mul_unit #(.BITS_PER_CYCLE(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start4), .ALUInstruction(Ins4),
        .A(A4), .B(B4), .Stall(Stall4), .Busy(Busy4), .Done(Done4),
        .HiLoOut(HiLoOut4), .HI(HI4), .LO(LO4)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int busy_cnt, output int done_cnt);
        Start = 1'b1; Ins = op; A = a; B = b;
        tick();
        Start = 1'b0; Ins = ADD;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (Busy) busy_cnt++;
            if (Done) done_cnt++;
            tick();
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Ins = ADD; A = '0; B = '0;
        Start4 = 1'b0; Ins4 = ADD; A4 = '0; B4 = '0;
        repeat (3) tick();
        Reset = 1'b0;
        chk("reset_hi", {32'd0, HI}, 64'd0);
        chk("reset_lo", {32'd0, LO}, 64'd0);
        chk("reset_busy", {63'd0, Busy}, 64'd0);
        chk("reset_done", {63'd0, Done}, 64'd0);

        // MULT -3 * 7
        run_mul(MULT, 32'hFFFF_FFFD, 32'd7, bc, dc);
        chk("mult_busy_cycles", 64'(bc), 64'd33);
        chk("mult_done_pulses", 64'(dc), 64'd1);
        chk("mult_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

        // MULTU max * max
        run_mul(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
        chk("multu_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

        // MTHI / MTLO then MADD, MSUB
        Start = 1'b1; Ins = MTHI; A = 32'd0;
        tick();
        Ins = MTLO; A = 32'd10;
        tick();
        Start = 1'b0; Ins = ADD;
        chk("mt_hilo", {HI, LO}, 64'd10);
        chk("mt_busy", {63'd0, Busy}, 64'd0);
        run_mul(MADD, 32'd4, 32'd5, bc, dc);
        chk("madd_hilo", {HI, LO}, 64'd30);
        run_mul(MSUB, 32'h8000_0000, 32'h8000_0000, bc, dc);
        chk("msub_hilo", {HI, LO}, 64'hC000_0000_0000_001E);

        // MULT 5 * -6 with MFLO held against the stall; one ADD in between
        Start = 1'b1; Ins = MULT; A = 32'd5; B = 32'hFFFF_FFFA;
        tick();
        Ins = MFLO;
        #1;
        chk("mflo_old_lo", {32'd0, HiLoOut}, 64'h1E);
        cyc = 0;
        for (int i = 0; i < 60 && Busy; i++) begin
            Ins = (i == 5) ? ADD : MFLO;
            #1;
            if (i == 5) chk("stall_add", {63'd0, Stall}, 64'd0);
            else        chk("stall_mflo", {63'd0, Stall}, 64'd1);
            cyc++;
            tick();
        end
        Ins = MFLO;
        #1;
        chk("stall_cycles", 64'(cyc), 64'd33);
        chk("stall_released", {63'd0, Stall}, 64'd0);
        chk("mflo_new_lo", {32'd0, HiLoOut}, 64'hFFFF_FFE2);
        chk("stall_done", {63'd0, Done}, 64'd1);
        Ins = MFHI;
        #1;
        chk("mfhi_out", {32'd0, HiLoOut}, 64'hFFFF_FFFF);
        Ins = ADD;
        #1;
        chk("other_out_zero", {32'd0, HiLoOut}, 64'd0);
        tick();
        Start = 1'b0;

        // Reset at ITER cycle 10
        Start = 1'b1; Ins = MULT; A = 32'd3; B = 32'd4;
        tick();
        Start = 1'b0; Ins = ADD;
        repeat (10) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_hilo", {HI, LO}, 64'd0);
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) dc++;
            tick();
        end
        chk("abort_no_done", 64'(dc), 64'd0);
        run_mul(MULTU, 32'd6, 32'd7, bc, dc);
        chk("after_abort_hilo", {HI, LO}, 64'd42);

        // BITS_PER_CYCLE=4 instance
        Start4 = 1'b1; Ins4 = MULT; A4 = 32'hFFFF_FFFD; B4 = 32'd7;
        tick();
        Start4 = 1'b0; Ins4 = ADD;
        bc = 0; dc = 0;
        for (int i = 0; i < 30; i++) begin
            if (Busy4) bc++;
            if (Done4) dc++;
            tick();
        end
        chk("bpc4_busy_cycles", 64'(bc), 64'd9);
        chk("bpc4_done_pulses", 64'(dc), 64'd1);
        chk("bpc4_hilo", {HI4, LO4}, 64'hFFFF_FFFF_FFFF_FFEB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
